featuremap_pad_writer: RTL and testbench

FEATUREMAP_PAD_WRITER -- requirements
Module: featuremap_pad_writer

---
 rtl/featuremap_pad_writer.sv | 93 +++++++++
 tb/tb_featuremap_pad_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/featuremap_pad_writer.sv
// Streams an unpadded raster feature map into a FIFO, wrapping it in a one-pixel ring of +0.0.
// Zero latency: pixels pass straight through to data_out in the cycle they are accepted.
module featuremap_pad_writer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 112,
  parameter int unsigned HEIGHT     = 112
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  fifo_full,
  output logic                  wrreq,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam int unsigned RW = $clog2(HEIGHT + 2);
  localparam logic [CW-1:0] CLast = CW'(WIDTH + 1);
  localparam logic [RW-1:0] RLast = RW'(HEIGHT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] c_q;
  logic [RW-1:0] r_q;
  logic          busy_q;
  logic          done_q;

  logic run, pad, last_col, last_row;

  // Reset also masks the combinational strobes so no write leaks out in the reset cycle.
  assign run      = (state_q == StRun) && !rst;
  assign last_col = (c_q == CLast);
  assign last_row = (r_q == RLast);
  assign pad      = (r_q == '0) || last_row || (c_q == '0) || last_col;

  assign wrreq      = run && !fifo_full && (pad || valid_in);
  assign ready_out  = run && !pad && !fifo_full;
  assign data_out   = (run && !pad) ? data_in : '0;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (wrreq) begin
            if (last_col) begin
              c_q <= '0;
              if (last_row) begin
                r_q     <= '0;
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                r_q <= r_q + RW'(1);
              end
            end else begin
              c_q <= c_q + CW'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Directed and randomized checks of featuremap_pad_writer against a queue-based frame model.
module tb_featuremap_pad_writer;

  localparam int unsigned SW = 2;
  localparam int unsigned SH = 2;
  localparam int unsigned LW = 112;
  localparam int unsigned LH = 112;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, valid_in, fifo_full;
  logic [31:0] data_in;
  logic        rdy_s, wr_s, busy_s, done_s;
  logic [31:0] dout_s;
  logic        rdy_l, wr_l, busy_l, done_l;
  logic [31:0] dout_l;

  featuremap_pad_writer #(.DATA_WIDTH(32), .WIDTH(SW), .HEIGHT(SH)) dut_s (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_s), .fifo_full(fifo_full), .wrreq(wr_s), .data_out(dout_s),
    .busy(busy_s), .frame_done(done_s)
  );

  featuremap_pad_writer dut_l (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_l), .fifo_full(fifo_full), .wrreq(wr_l), .data_out(dout_l),
    .busy(busy_l), .frame_done(done_l)
  );

  int n_pass = 0;
  int n_total = 0;
  bit sel = 1'b0;
  bit src_en = 1'b0;
  int cyc = 0;
  int wr_cnt, done_cnt, first_wr, last_wr, done_cyc;
  logic [31:0] src_q[$], pix_q[$], exp_q[$], out_q[$], acc_q[$];
  logic        s_wr, s_rdy, s_busy, s_done;
  logic [31:0] s_dout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive the pixel source, sample outputs at negedge, retire accepted pixel.
  task automatic cycle();
    bit acc;
    valid_in = src_en && (src_q.size() > 0);
    data_in  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    @(negedge clk);
    s_wr   = sel ? wr_l   : wr_s;
    s_rdy  = sel ? rdy_l  : rdy_s;
    s_busy = sel ? busy_l : busy_s;
    s_done = sel ? done_l : done_s;
    s_dout = sel ? dout_l : dout_s;
    if (s_wr === 1'b1) begin
      out_q.push_back(s_dout);
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
    end
    if (s_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    acc = (s_rdy === 1'b1) && valid_in;
    @(posedge clk);
    #1;
    if (acc) acc_q.push_back(src_q.pop_front());
    cyc++;
  endtask

  task automatic clear_log();
    out_q.delete();
    acc_q.delete();
    wr_cnt = 0; done_cnt = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
  endtask

  task automatic load_small();
    pix_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    src_q = pix_q;
  endtask

  // Model: padded frame is the raster of pixels surrounded by a ring of zeros.
  task automatic build_exp(input int w, input int h);
    int k = 0;
    exp_q.delete();
    for (int r = 0; r < h + 2; r++)
      for (int c = 0; c < w + 2; c++)
        if (r == 0 || r == h + 1 || c == 0 || c == w + 1) exp_q.push_back(32'h0);
        else exp_q.push_back(pix_q[k++]);
  endtask

  task automatic check_frame(input string tag);
    int bad = 0;
    check({tag, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (out_q[i] !== exp_q[i]) bad++;
    check({tag, "_words_bad"}, bad, 0);
    bad = 0;
    check({tag, "_acc_len"}, acc_q.size(), pix_q.size());
    for (int i = 0; i < acc_q.size() && i < pix_q.size(); i++)
      if (acc_q[i] !== pix_q[i]) bad++;
    check({tag, "_acc_bad"}, bad, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; src_en = 1'b0; fifo_full = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; fifo_full = 1'b0; data_in = '0;
    clear_log();

    // Reset values
    do_reset();
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_wrreq", s_wr, 0);
    check("rst_ready", s_rdy, 0);
    check("rst_dout", s_dout, 0);
    cycle();
    check("idle_wrreq", s_wr, 0);

    // Plain 2x2 frame, valid held, no backpressure
    load_small(); clear_log(); build_exp(SW, SH); src_en = 1'b1;
    pulse_start();
    run_to_done("t1", 100);
    repeat (3) cycle();
    check_frame("t1");
    check("t1_wr_cnt", wr_cnt, 16);
    check("t1_consec", last_wr - first_wr, 15);
    check("t1_done_cyc", done_cyc, last_wr + 1);
    check("t1_done_cnt", done_cnt, 1);

    // fifo_full for 3 cycles at the first data word
    load_small(); clear_log(); build_exp(SW, SH); src_en = 1'b1;
    pulse_start();
    n = 0;
    while (wr_cnt < 5 && n < 50) begin cycle(); n++; end
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_full_wrreq", s_wr, 0);
      check("t2_full_ready", s_rdy, 0);
    end
    fifo_full = 1'b0;
    run_to_done("t2", 100);
    repeat (3) cycle();
    check_frame("t2");
    check("t2_done_cnt", done_cnt, 1);

    // Pads written without valid_in; valid_in gap at (2,1)
    load_small(); clear_log(); build_exp(SW, SH); src_en = 1'b0;
    pulse_start();
    repeat (8) cycle();
    check("t3_pad_writes", wr_cnt, 5);
    check("t3_src_left", src_q.size(), 4);
    src_en = 1'b1;
    n = 0;
    while (wr_cnt < 9 && n < 50) begin cycle(); n++; end
    src_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("t3_gap_wrreq", s_wr, 0);
    end
    src_en = 1'b1;
    run_to_done("t3", 100);
    repeat (3) cycle();
    check_frame("t3");

    // Reset after the 7th write, then a full fresh frame
    load_small(); clear_log(); src_en = 1'b1;
    pulse_start();
    n = 0;
    while (wr_cnt < 7 && n < 50) begin cycle(); n++; end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("t4_busy_after_rst", s_busy, 0);
    check("t4_wrreq_after_rst", s_wr, 0);
    check("t4_wr_cnt_abandoned", wr_cnt, 7);
    load_small(); clear_log(); build_exp(SW, SH);
    pulse_start();
    run_to_done("t4", 100);
    repeat (3) cycle();
    check_frame("t4");
    check("t4_wr_cnt", wr_cnt, 16);

    // start mid-frame and on the frame_done cycle is ignored
    load_small(); clear_log(); build_exp(SW, SH); src_en = 1'b1;
    pulse_start();
    repeat (6) cycle();
    pulse_start();
    n = 0;
    while (done_cnt == 0 && n < 100) begin
      start = (wr_cnt == 16);
      cycle();
      n++;
    end
    start = 1'b0;
    repeat (10) cycle();
    check("t5_wr_cnt", wr_cnt, 16);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_busy", s_busy, 0);
    check_frame("t5");

    // Default-size frame with random backpressure and valid gaps
    sel = 1'b1;
    do_reset();
    clear_log();
    pix_q.delete();
    for (int i = 0; i < LW * LH; i++) pix_q.push_back($urandom);
    src_q = pix_q;
    build_exp(LW, LH);
    src_en = 1'b1;
    pulse_start();
    n = 0;
    while (done_cnt == 0 && n < 60000) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      src_en    = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
    end
    fifo_full = 1'b0;
    repeat (3) cycle();
    check("t6_wr_cnt", wr_cnt, 12996);
    check("t6_acc_cnt", acc_q.size(), 12544);
    check("t6_done_cnt", done_cnt, 1);
    check_frame("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
